// File: rtl/idex_operand_reg_pkg.sv
// Shared configuration for the ID/EX operand register: datapath width,
// ALU op codes and operand-select encodings.
package idex_operand_reg_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned RIDX_W = 5;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;

  localparam logic [1:0] B_SEL_RS2  = 2'd0;
  localparam logic [1:0] B_SEL_IMM  = 2'd1;
  localparam logic [1:0] B_SEL_FOUR = 2'd2;
  localparam logic [1:0] B_SEL_ZERO = 2'd3;

endpackage

// File: rtl/idex_operand_reg_fwd_sel.sv
// Writeback forwarding mux for one source operand; x0 is never forwarded.
module idex_operand_reg_fwd_sel #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RIDX_W = 5
) (
  input  logic [RIDX_W-1:0] src_idx,
  input  logic [XLEN-1:0]   src_data,
  input  logic              fwd_wen,
  input  logic [RIDX_W-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]   data
);

  logic hit;

  assign hit  = fwd_wen && (fwd_rd == src_idx) && (src_idx != '0);
  assign data = hit ? fwd_data : src_data;

endmodule

// File: rtl/idex_operand_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, writeback
// forwarding at capture and during stalls, and a registered operand select.
module idex_operand_reg
  import idex_operand_reg_pkg::*;
#(
  parameter int unsigned XLEN   = idex_operand_reg_pkg::XLEN,
  parameter int unsigned RIDX_W = idex_operand_reg_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [RIDX_W-1:0] id_rs1_idx_i,
  input  logic [RIDX_W-1:0] id_rs2_idx_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic              id_a_sel_i,
  input  logic [1:0]        id_b_sel_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic [RIDX_W-1:0] id_rd_i,
  input  logic              id_rd_wen_i,
  input  logic              flush_i,
  input  logic              fwd_wen_i,
  input  logic [RIDX_W-1:0] fwd_rd_i,
  input  logic [XLEN-1:0]   fwd_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_op_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs2_o,
  output logic [RIDX_W-1:0] ex_rd_o,
  output logic              ex_rd_wen_o
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
  logic [RIDX_W-1:0] rs1_idx_q, rs2_idx_q, rd_q;
  logic              a_sel_q, rd_wen_q;
  logic [1:0]        b_sel_q;
  logic [3:0]        alu_op_q;

  logic              hold, capture;
  logic [RIDX_W-1:0] rs1_src_idx, rs2_src_idx;
  logic [XLEN-1:0]   rs1_src_data, rs2_src_data, rs1_fwd, rs2_fwd;

  assign id_ready_o = ~valid_q | ex_ready_i;
  assign hold       = valid_q & ~ex_ready_i;
  assign capture    = id_valid_i & id_ready_o;

  // Hold and capture are mutually exclusive, so one mux per operand serves both:
  // a stalled entry re-forwards its own data, otherwise the incoming ID data is used.
  assign rs1_src_idx  = hold ? rs1_idx_q : id_rs1_idx_i;
  assign rs1_src_data = hold ? rs1_q     : id_rs1_data_i;
  assign rs2_src_idx  = hold ? rs2_idx_q : id_rs2_idx_i;
  assign rs2_src_data = hold ? rs2_q     : id_rs2_data_i;

  idex_operand_reg_fwd_sel #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
    .src_idx  (rs1_src_idx),
    .src_data (rs1_src_data),
    .fwd_wen  (fwd_wen_i),
    .fwd_rd   (fwd_rd_i),
    .fwd_data (fwd_data_i),
    .data     (rs1_fwd)
  );

  idex_operand_reg_fwd_sel #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
    .src_idx  (rs2_src_idx),
    .src_data (rs2_src_data),
    .fwd_wen  (fwd_wen_i),
    .fwd_rd   (fwd_rd_i),
    .fwd_data (fwd_data_i),
    .data     (rs2_fwd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rd_q      <= '0;
      a_sel_q   <= A_SEL_RS1;
      b_sel_q   <= B_SEL_RS2;
      alu_op_q  <= '0;
      rd_wen_q  <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      pc_q      <= id_pc_i;
      rs1_q     <= rs1_fwd;
      rs2_q     <= rs2_fwd;
      imm_q     <= id_imm_i;
      rs1_idx_q <= id_rs1_idx_i;
      rs2_idx_q <= id_rs2_idx_i;
      rd_q      <= id_rd_i;
      a_sel_q   <= id_a_sel_i;
      b_sel_q   <= id_b_sel_i;
      alu_op_q  <= id_alu_op_i;
      rd_wen_q  <= id_rd_wen_i;
    end else if (valid_q && ex_ready_i) begin
      valid_q <= 1'b0;
    end else if (hold) begin
      rs1_q <= rs1_fwd;
      rs2_q <= rs2_fwd;
    end
  end

  assign alu_a_o = (a_sel_q == A_SEL_PC) ? pc_q : rs1_q;

  always_comb begin
    alu_b_o = '0;
    unique case (b_sel_q)
      B_SEL_RS2:  alu_b_o = rs2_q;
      B_SEL_IMM:  alu_b_o = imm_q;
      B_SEL_FOUR: alu_b_o = XLEN'(4);
      B_SEL_ZERO: alu_b_o = '0;
      default:    alu_b_o = '0;
    endcase
  end

  assign alu_op_o    = alu_op_q;
  assign ex_valid_o  = valid_q;
  assign ex_pc_o     = pc_q;
  assign ex_rs2_o    = rs2_q;
  assign ex_rd_o     = rd_q;
  assign ex_rd_wen_o = rd_wen_q & valid_q;

endmodule

// File: tb/tb_idex_operand_reg.sv
// Scoreboard bench for idex_operand_reg: directed scenarios then random traffic,
// checked against a queue-based model of the pending instruction.
module tb_idex_operand_reg;
  import idex_operand_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_ready_o;
  logic [63:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_idx_i, id_rs2_idx_i, id_rd_i;
  logic        id_a_sel_i, id_rd_wen_i;
  logic [1:0]  id_b_sel_i;
  logic [3:0]  id_alu_op_i;
  logic        flush_i, fwd_wen_i;
  logic [4:0]  fwd_rd_i;
  logic [63:0] fwd_data_i;
  logic        ex_valid_o, ex_ready_i;
  logic [63:0] alu_a_o, alu_b_o, ex_pc_o, ex_rs2_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  ex_rd_o;
  logic        ex_rd_wen_o;

  idex_operand_reg #(.XLEN(64), .RIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_a_sel_i(id_a_sel_i), .id_b_sel_i(id_b_sel_i), .id_alu_op_i(id_alu_op_i),
    .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i), .flush_i(flush_i),
    .fwd_wen_i(fwd_wen_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .ex_pc_o(ex_pc_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_rd_wen_o(ex_rd_wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rs1_idx, rs2_idx, rd;
    logic        a_sel, rd_wen;
    logic [1:0]  b_sel;
    logic [3:0]  op;
  } entry_t;

  entry_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  logic   rst_seen = 1'b0;

  function automatic logic [63:0] fwd_val(logic [4:0] idx, logic [63:0] d);
    if (fwd_wen_i && fwd_rd_i == idx && idx != 5'd0) return fwd_data_i;
    return d;
  endfunction

  function automatic logic [63:0] exp_b(entry_t e);
    case (e.b_sel)
      2'd0:    return e.rs2;
      2'd1:    return e.imm;
      2'd2:    return 64'd4;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, req);
    end
  endtask

  // Reference model: the stage holds at most one instruction; it is accepted
  // whenever the slot is free (the monitor frees it on consumption).
  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst || flush_i) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (!ex_ready_i) begin
        exp_q[0].rs1 = fwd_val(exp_q[0].rs1_idx, exp_q[0].rs1);
        exp_q[0].rs2 = fwd_val(exp_q[0].rs2_idx, exp_q[0].rs2);
      end
    end else if (id_valid_i) begin
      entry_t e;
      e.pc = id_pc_i; e.imm = id_imm_i;
      e.rs1_idx = id_rs1_idx_i; e.rs2_idx = id_rs2_idx_i;
      e.rs1 = fwd_val(id_rs1_idx_i, id_rs1_data_i);
      e.rs2 = fwd_val(id_rs2_idx_i, id_rs2_data_i);
      e.a_sel = id_a_sel_i; e.b_sel = id_b_sel_i; e.op = id_alu_op_i;
      e.rd = id_rd_i; e.rd_wen = id_rd_wen_i;
      exp_q.push_back(e);
    end
  end

  // Monitor: inspects outputs mid-cycle and retires the entry when EX takes it.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_alu_a", alu_a_o, 64'd0);
      check("reset_alu_b", alu_b_o, 64'd0);
      check("reset_alu_op", {60'd0, alu_op_o}, 64'd0);
      check("reset_rd_wen", {63'd0, ex_rd_wen_o}, 64'd0);
    end
    if (!rst) begin
      check("id_ready", {63'd0, id_ready_o}, {63'd0, (exp_q.size() == 0) || ex_ready_i});
      check("ex_valid", {63'd0, ex_valid_o}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() == 0) begin
        check("idle_rd_wen", {63'd0, ex_rd_wen_o}, 64'd0);
      end else if (ex_valid_o) begin
        check("alu_a", alu_a_o, exp_q[0].a_sel ? exp_q[0].pc : exp_q[0].rs1);
        check("alu_b", alu_b_o, exp_b(exp_q[0]));
        check("alu_op", {60'd0, alu_op_o}, {60'd0, exp_q[0].op});
        check("ex_pc", ex_pc_o, exp_q[0].pc);
        check("ex_rs2", ex_rs2_o, exp_q[0].rs2);
        check("ex_rd", {59'd0, ex_rd_o}, {59'd0, exp_q[0].rd});
        check("ex_rd_wen", {63'd0, ex_rd_wen_o}, {63'd0, exp_q[0].rd_wen});
        if (ex_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 1'b0; flush_i = 1'b0; fwd_wen_i = 1'b0;
    fwd_rd_i = '0; fwd_data_i = '0;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [4:0] r1i, input logic [63:0] r1d,
                       input logic [4:0] r2i, input logic [63:0] r2d, input logic [63:0] imm,
                       input logic asel, input logic [1:0] bsel, input logic [3:0] op,
                       input logic [4:0] rd);
    id_valid_i = 1'b1; id_pc_i = pc;
    id_rs1_idx_i = r1i; id_rs1_data_i = r1d;
    id_rs2_idx_i = r2i; id_rs2_data_i = r2d;
    id_imm_i = imm; id_a_sel_i = asel; id_b_sel_i = bsel;
    id_alu_op_i = op; id_rd_i = rd; id_rd_wen_i = 1'b1;
  endtask

  task automatic fwd(input logic [4:0] rd, input logic [63:0] d);
    fwd_wen_i = 1'b1; fwd_rd_i = rd; fwd_data_i = d;
  endtask

  initial begin
    rst = 1'b1; ex_ready_i = 1'b1;
    idle();
    issue(64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 1'b0, 2'd0, 4'd0, 5'd0);
    id_valid_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // basic flow and back-to-back
    issue(64'h8000_0000, 5'd1, 64'h1234, 5'd2, 64'h99, 64'h10, 1'b1, 2'd2, ALUOP_ADD, 5'd3);
    tick();
    issue(64'h8000_0004, 5'd1, 64'h7, 5'd2, 64'h9, 64'h20, 1'b0, 2'd1, ALUOP_SUB, 5'd4);
    tick(); idle(); tick();

    // stall with a second offer pending
    ex_ready_i = 1'b0;
    issue(64'h100, 5'd1, 64'h11, 5'd2, 64'h22, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd5);
    tick();
    issue(64'h104, 5'd3, 64'h33, 5'd4, 64'h44, 64'h0, 1'b0, 2'd3, ALUOP_SUB, 5'd6);
    tick(); tick();
    ex_ready_i = 1'b1;
    tick(); idle(); tick();

    // capture forwarding, then x0 source not forwarded
    issue(64'h200, 5'd5, 64'h1, 5'd0, 64'h2, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd1);
    fwd(5'd5, 64'hDEAD);
    tick();
    issue(64'h204, 5'd0, 64'h1, 5'd0, 64'h2, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd1);
    fwd(5'd0, 64'hDEAD);
    tick(); idle(); tick();

    // forwarding into a held entry
    ex_ready_i = 1'b0;
    issue(64'h300, 5'd1, 64'h5, 5'd7, 64'h6, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd2);
    tick(); idle();
    fwd(5'd7, 64'h55);
    tick(); idle(); tick();
    ex_ready_i = 1'b1;
    tick();

    // flush with handshake, then flush of a held entry
    issue(64'h400, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd2);
    flush_i = 1'b1;
    tick(); idle(); tick();
    ex_ready_i = 1'b0;
    issue(64'h404, 5'd1, 64'h5, 5'd2, 64'h6, 64'h0, 1'b0, 2'd0, ALUOP_ADD, 5'd2);
    tick(); idle(); flush_i = 1'b1;
    tick(); idle(); tick();

    // reset while stalled
    issue(64'h500, 5'd1, 64'hAB, 5'd2, 64'hCD, 64'h0, 1'b1, 2'd1, ALUOP_SUB, 5'd9);
    tick(); idle(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ex_ready_i = 1'b1;

    for (int unsigned i = 0; i < 3000; i++) begin
      id_valid_i    = ($urandom_range(0, 9) < 7);
      id_pc_i       = {$urandom, $urandom};
      id_rs1_idx_i  = 5'($urandom_range(0, 7));
      id_rs2_idx_i  = 5'($urandom_range(0, 7));
      id_rs1_data_i = {$urandom, $urandom};
      id_rs2_data_i = {$urandom, $urandom};
      id_imm_i      = {$urandom, $urandom};
      id_a_sel_i    = 1'($urandom);
      id_b_sel_i    = 2'($urandom);
      id_alu_op_i   = 4'($urandom);
      id_rd_i       = 5'($urandom);
      id_rd_wen_i   = 1'($urandom);
      ex_ready_i    = ($urandom_range(0, 9) < 6);
      flush_i       = ($urandom_range(0, 99) < 8);
      fwd_wen_i     = 1'($urandom);
      fwd_rd_i      = 5'($urandom_range(0, 7));
      fwd_data_i    = {$urandom, $urandom};
      rst           = ($urandom_range(0, 99) < 2);
      tick();
    end
    idle(); rst = 1'b0; ex_ready_i = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
